cpu_mem: RTL

CPU_MEM -- requirements
Module: cpu_mem

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/cpu_mem_ram.sv | 27 ++
 rtl/cpu_mem.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU memory/loader block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int IMSB_DEF            = 15;
    localparam int PMSB_DEF            = 7;
    localparam int AMSB_DEF            = 7;
    localparam int DMSB_DEF            = 7;
    localparam int CYCLES_W            = 16;
    localparam int LOAD_BYTES_PER_WORD = 2;
    localparam int LOAD_WORD_W         = 8 * LOAD_BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_CNT = 3'd1,
        LOAD_LO  = 3'd2,
        LOAD_HI  = 3'd3,
        RUN      = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_mem_ram.sv
// Generic memory array: combinational read port, write-enabled synchronous write port.
// Latency: read 0 cycles, write visible after the clk edge.
// Backpressure: none; a write is taken on every edge with we high.
module cpu_mem_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // Deliberately unreset: contents are undefined until written.
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem.sv
// Program loader plus instruction/data memories for a small CPU, with run control.
// Latency: inst/rdata 0 cycles; load byte consumed on the accepting edge; setn/cpu_rstn registered.
// Backpressure: load_ready high only in the three load states; bytes offered elsewhere are ignored.
module cpu_mem
    import cpu_pkg::*;
#(
    parameter int IMSB = IMSB_DEF,
    parameter int PMSB = PMSB_DEF,
    parameter int AMSB = AMSB_DEF,
    parameter int DMSB = DMSB_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [7:0]          load_data,
    output logic                load_ready,
    input  logic                run_stop,
    input  logic [PMSB:0]       pc,
    output logic [IMSB:0]       inst,
    input  logic [AMSB:0]       addr,
    input  logic [DMSB:0]       wdata,
    input  logic                write,
    output logic [DMSB:0]       rdata,
    output logic                setn,
    output logic                cpu_rstn,
    output logic                running,
    output logic [CYCLES_W-1:0] cycles
);

    localparam int PW = PMSB + 1;
    localparam int IW = IMSB + 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [PMSB:0]          widx;
    logic [PMSB:0]          word_cnt;
    logic [7:0]             lo_byte;
    logic                   load_acc;
    logic                   last_word;
    logic                   imem_we;
    logic                   dmem_we;
    logic [LOAD_WORD_W-1:0] load_word;
    logic [IMSB:0]          imem_wdata;

    assign load_ready = (state == LOAD_CNT) || (state == LOAD_LO) || (state == LOAD_HI);
    assign load_acc   = load_valid && load_ready;
    assign running    = (state == RUN);

    // A stored count of 0 makes word_cnt-1 the all-ones index, i.e. a full memory.
    assign last_word  = (widx == (word_cnt - {{PMSB{1'b0}}, 1'b1}));

    assign load_word  = {load_data, lo_byte};
    assign imem_wdata = IW'(load_word);

    // Gated by rstn so an edge seen while reset is held never commits a write.
    assign imem_we = rstn && (state == LOAD_HI) && load_acc && !load_start;
    assign dmem_we = rstn && write && setn;

    always_comb begin
        state_nxt = state;
        if (load_start) begin
            state_nxt = LOAD_CNT;
        end else begin
            case (state)
                LOAD_CNT: if (load_acc) state_nxt = LOAD_LO;
                LOAD_LO:  if (load_acc) state_nxt = LOAD_HI;
                LOAD_HI:  if (load_acc) state_nxt = last_word ? RUN : LOAD_LO;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            widx     <= '0;
            word_cnt <= '0;
            lo_byte  <= '0;
            setn     <= 1'b0;
            cpu_rstn <= 1'b0;
            cycles   <= '0;
        end else begin
            state    <= state_nxt;
            setn     <= (state_nxt == RUN) && !run_stop;
            cpu_rstn <= (state_nxt == RUN);
            if (load_start) begin
                widx   <= '0;
                cycles <= '0;
            end else begin
                if ((state == LOAD_CNT) && load_acc) begin
                    word_cnt <= PW'(load_data);
                end
                if ((state == LOAD_LO) && load_acc) begin
                    lo_byte <= load_data;
                end
                if (imem_we) begin
                    widx <= widx + 1'b1;
                end
                if (running && setn && (cycles != {CYCLES_W{1'b1}})) begin
                    cycles <= cycles + 1'b1;
                end
            end
        end
    end

    cpu_mem_ram #(.AW(PMSB + 1), .DW(IMSB + 1)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (widx),
        .wdata (imem_wdata),
        .raddr (pc),
        .rdata (inst)
    );

    cpu_mem_ram #(.AW(AMSB + 1), .DW(DMSB + 1)) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .waddr (addr),
        .wdata (wdata),
        .raddr (addr),
        .rdata (rdata)
    );

endmodule
